gerador_passo_torreta: RTL and testbench



---
 rtl/torreta_pkg.sv | 33 +++
 rtl/debounce_botao.sv | 42 ++++
 rtl/gerador_passo_torreta.sv | 163 ++++++++++++++++
 tb/tb_gerador_passo_torreta.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/torreta_pkg.sv
// Shared definitions for the turret step generator: FSM states, direction
// codes, acceleration threshold and the button-pair direction decoder.
package torreta_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ATRASO  = 2'd1,
    REPETE  = 2'd2,
    TRAVADO = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    NENHUM = 2'd0,
    SOMA   = 2'd1,
    SUB    = 2'd2,
    AMBOS  = 2'd3
  } direcao_t;

  // Repeat pulses needed before the repeat period is halved.
  localparam int LIMIAR_ACEL = 8;

  function automatic direcao_t decodifica(input logic esq, input logic dir);
    direcao_t d;
    case ({esq, dir})
      2'b01:   d = SOMA;
      2'b10:   d = SUB;
      2'b11:   d = AMBOS;
      default: d = NENHUM;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchroniser followed by a stability-count debouncer for one raw
// push-button; the clean level only moves after N_DEB agreeing samples.
module debounce_botao #(
  parameter int N_DEB = 50000
) (
  input  logic clock,
  input  logic zera_s,
  input  logic botao,
  output logic nivel
);

  localparam int W_DEB = (N_DEB > 1) ? $clog2(N_DEB) : 1;

  logic             sinc1_r;
  logic             sinc2_r;
  logic             nivel_r;
  logic [W_DEB-1:0] cont_r;

  // Synchroniser chain, disagreement counter and debounced level.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      sinc1_r <= 1'b0;
      sinc2_r <= 1'b0;
      nivel_r <= 1'b0;
      cont_r  <= '0;
    end else begin
      sinc1_r <= botao;
      sinc2_r <= sinc1_r;
      if (sinc2_r == nivel_r) begin
        cont_r <= '0;
      end else if (cont_r == W_DEB'(N_DEB - 1)) begin
        nivel_r <= ~nivel_r;
        cont_r  <= '0;
      end else begin
        cont_r <= cont_r + 1'b1;
      end
    end
  end

  assign nivel = nivel_r;

endmodule

// File: rtl/gerador_passo_torreta.sv
// Turret step generator: debounced left/right buttons become single-cycle
// soma/sub pulses with tap/auto-repeat. Optional TORRETA_ACELERACAO_EN halves
// the repeat period after a run of repeat pulses.
module gerador_passo_torreta
  import torreta_pkg::*;
#(
  parameter int N_DEB    = 50000,
  parameter int N_ATRASO = 25000000,
  parameter int N_REPETE = 5000000
) (
  input  logic clock,
  input  logic zera_s,
  input  logic habilita,
  input  logic botao_esq,
  input  logic botao_dir,
  output logic soma,
  output logic sub,
  output logic ativo
);

  localparam int N_MAX   = (N_ATRASO > N_REPETE) ? N_ATRASO : N_REPETE;
  localparam int W_TEMPO = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  logic               esq_db_s;
  logic               dir_db_s;
  direcao_t           dir_cmd_s;
  estado_t            estado_r;
  estado_t            estado_prox_s;
  direcao_t           dir_trav_r;
  direcao_t           dir_trav_prox_s;
  logic [W_TEMPO-1:0] tempo_r;
  logic [W_TEMPO-1:0] tempo_prox_s;
  logic [W_TEMPO-1:0] limite_repete_s;
  logic               pulso_s;
  logic               soma_r;
  logic               sub_r;
  logic               ativo_r;

  debounce_botao #(.N_DEB(N_DEB)) u_deb_esq (
    .clock  (clock),
    .zera_s (zera_s),
    .botao  (botao_esq),
    .nivel  (esq_db_s)
  );

  debounce_botao #(.N_DEB(N_DEB)) u_deb_dir (
    .clock  (clock),
    .zera_s (zera_s),
    .botao  (botao_dir),
    .nivel  (dir_db_s)
  );

  assign dir_cmd_s = decodifica(esq_db_s, dir_db_s);

`ifdef TORRETA_ACELERACAO_EN
  logic [3:0] rep_r;
  logic [3:0] rep_prox_s;

  // Repeat-pulse counter: saturates at the threshold, clears when the hold ends.
  always_comb begin
    rep_prox_s = rep_r;
    if ((estado_prox_s == OCIOSO) || (estado_prox_s == TRAVADO)) begin
      rep_prox_s = 4'd0;
    end else if ((estado_r == REPETE) && pulso_s && (rep_r < 4'(LIMIAR_ACEL))) begin
      rep_prox_s = rep_r + 4'd1;
    end else begin
      rep_prox_s = rep_r;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      rep_r <= 4'd0;
    end else begin
      rep_r <= rep_prox_s;
    end
  end

  assign limite_repete_s = (rep_r >= 4'(LIMIAR_ACEL)) ? W_TEMPO'((N_REPETE / 2) - 1)
                                                       : W_TEMPO'(N_REPETE - 1);
`else
  assign limite_repete_s = W_TEMPO'(N_REPETE - 1);
`endif

  // Next-state, timer and pulse decision; habilita low always forces OCIOSO.
  always_comb begin
    estado_prox_s   = estado_r;
    dir_trav_prox_s = dir_trav_r;
    tempo_prox_s    = '0;
    pulso_s         = 1'b0;
    if (!habilita) begin
      estado_prox_s = OCIOSO;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if ((dir_cmd_s == SOMA) || (dir_cmd_s == SUB)) begin
            dir_trav_prox_s = dir_cmd_s;
            pulso_s         = 1'b1;
            estado_prox_s   = ATRASO;
          end else if (dir_cmd_s == AMBOS) begin
            estado_prox_s = TRAVADO;
          end else begin
            estado_prox_s = OCIOSO;
          end
        end
        ATRASO: begin
          if (dir_cmd_s != dir_trav_r) begin
            estado_prox_s = (dir_cmd_s == AMBOS) ? TRAVADO : OCIOSO;
          end else if (tempo_r == W_TEMPO'(N_ATRASO - 1)) begin
            pulso_s       = 1'b1;
            estado_prox_s = REPETE;
          end else begin
            tempo_prox_s = tempo_r + 1'b1;
          end
        end
        REPETE: begin
          if (dir_cmd_s != dir_trav_r) begin
            estado_prox_s = (dir_cmd_s == AMBOS) ? TRAVADO : OCIOSO;
          end else if (tempo_r == limite_repete_s) begin
            pulso_s = 1'b1;
          end else begin
            tempo_prox_s = tempo_r + 1'b1;
          end
        end
        TRAVADO: begin
          if (dir_cmd_s == NENHUM) begin
            estado_prox_s = OCIOSO;
          end else begin
            estado_prox_s = TRAVADO;
          end
        end
        default: begin
          estado_prox_s = OCIOSO;
        end
      endcase
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado_r   <= OCIOSO;
      dir_trav_r <= NENHUM;
      tempo_r    <= '0;
      soma_r     <= 1'b0;
      sub_r      <= 1'b0;
      ativo_r    <= 1'b0;
    end else begin
      estado_r   <= estado_prox_s;
      dir_trav_r <= dir_trav_prox_s;
      tempo_r    <= tempo_prox_s;
      soma_r     <= pulso_s && (dir_trav_prox_s == SOMA);
      sub_r      <= pulso_s && (dir_trav_prox_s == SUB);
      ativo_r    <= (estado_prox_s == ATRASO) || (estado_prox_s == REPETE);
    end
  end

  assign soma  = soma_r;
  assign sub   = sub_r;
  assign ativo = ativo_r;

endmodule

// File: tb/tb_gerador_passo_torreta.sv
// Self-checking bench for gerador_passo_torreta: a schedule-based model
// (pulse due times rather than timers) is compared every cycle, plus fixed
// hand-computed pulse times for the directed scenarios.
module tb_gerador_passo_torreta;

  localparam int N_DEB    = 4;
  localparam int N_ATRASO = 20;
  localparam int N_REPETE = 8;

  logic clock     = 1'b0;
  logic zera_s    = 1'b1;
  logic habilita  = 1'b1;
  logic botao_esq = 1'b0;
  logic botao_dir = 1'b0;
  logic soma;
  logic sub;
  logic ativo;

  gerador_passo_torreta #(
    .N_DEB    (N_DEB),
    .N_ATRASO (N_ATRASO),
    .N_REPETE (N_REPETE)
  ) dut (
    .clock     (clock),
    .zera_s    (zera_s),
    .habilita  (habilita),
    .botao_esq (botao_esq),
    .botao_dir (botao_dir),
    .soma      (soma),
    .sub       (sub),
    .ativo     (ativo)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state. Index 0 = left button, index 1 = right button.
  int       t_model = 1;
  logic [1:0] m_s1 = 2'b00;
  logic [1:0] m_s2 = 2'b00;
  logic [1:0] m_db = 2'b00;
  int       m_ini [2] = '{-1, -1};
  int       m_modo  = 0;   // 0 idle, 1 held, 2 locked
  int       m_dir   = 0;   // 1 soma (right), 2 sub (left)
  int       m_prox  = 0;   // edge index at which the next step is due
  bit       m_em_rep = 1'b0;
  int       m_reps  = 0;
  logic     e_soma  = 1'b0;
  logic     e_sub   = 1'b0;
  logic     e_ativo = 1'b0;
  int       q_soma [$];
  int       q_sub  [$];

  task automatic chk_bit(input string nome, input logic atual, input logic esp);
    checks++;
    if (atual !== esp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%b expected=%b", nome, t_model, atual, esp);
    end
  endtask

  task automatic chk_int(input string nome, input int atual, input int esp);
    checks++;
    if (atual != esp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nome, atual, esp);
    end
  endtask

  function automatic int dec_m(input logic [1:0] db);
    if (db == 2'b10) return 1;
    else if (db == 2'b01) return 2;
    else if (db == 2'b11) return 3;
    else return 0;
  endfunction

  // One model step for edge t_model using the inputs that edge samples.
  task automatic passo_modelo();
    int dec;
    bit pulso;
    int periodo;
    pulso = 1'b0;
    if (zera_s) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_db = 2'b00;
      m_ini[0] = -1; m_ini[1] = -1;
      m_modo = 0; m_dir = 0; m_em_rep = 1'b0; m_reps = 0;
      e_soma = 1'b0; e_sub = 1'b0; e_ativo = 1'b0;
      return;
    end
    dec = dec_m(m_db);
    if (!habilita) begin
      m_modo = 0;
    end else begin
      case (m_modo)
        0: begin
          if (dec == 1 || dec == 2) begin
            m_dir = dec; pulso = 1'b1; m_prox = t_model + N_ATRASO;
            m_em_rep = 1'b0; m_reps = 0; m_modo = 1;
          end else if (dec == 3) begin
            m_modo = 2;
          end
        end
        1: begin
          if (dec != m_dir) begin
            m_modo = (dec == 3) ? 2 : 0;
          end else if (t_model == m_prox) begin
            pulso = 1'b1;
            if (m_em_rep) m_reps++;
            m_em_rep = 1'b1;
            periodo = N_REPETE;
`ifdef TORRETA_ACELERACAO_EN
            if (m_reps >= 8) periodo = N_REPETE / 2;
`endif
            m_prox = t_model + periodo;
          end
        end
        default: begin
          if (dec == 0) m_modo = 0;
        end
      endcase
    end
    e_soma  = pulso && (m_dir == 1);
    e_sub   = pulso && (m_dir == 2);
    e_ativo = (m_modo == 1);
    if (e_soma) q_soma.push_back(t_model);
    if (e_sub)  q_sub.push_back(t_model);
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] != m_db[b]) begin
        if (m_ini[b] < 0) m_ini[b] = t_model;
        if (t_model - m_ini[b] == N_DEB - 1) begin
          m_db[b]  = ~m_db[b];
          m_ini[b] = -1;
        end
      end else begin
        m_ini[b] = -1;
      end
    end
    m_s2 = m_s1;
    m_s1 = {botao_dir, botao_esq};
  endtask

  // Compare on the falling edge, then advance the model to the next edge.
  initial begin
    forever begin
      @(negedge clock);
      chk_bit("soma", soma, e_soma);
      chk_bit("sub", sub, e_sub);
      chk_bit("ativo", ativo, e_ativo);
      t_model++;
      passo_modelo();
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int esp_hold [6] = '{7, 27, 35, 43, 51, 59};
  int base;
  int n0;
  int n1;

  initial begin
    ciclos(3);
    zera_s = 1'b0;
    ciclos(5);

    // Tap: one soma at relative edge 7.
    base = t_model; n0 = q_soma.size(); n1 = q_sub.size();
    botao_dir = 1'b1;
    ciclos(10);
    botao_dir = 1'b0;
    ciclos(40);
    chk_int("tap_n_soma", q_soma.size() - n0, 1);
    if (q_soma.size() > n0) chk_int("tap_t_soma", q_soma[n0] - base, 7);
    chk_int("tap_n_sub", q_sub.size() - n1, 0);

    // Hold left for 60 cycles.
    base = t_model; n0 = q_soma.size(); n1 = q_sub.size();
    botao_esq = 1'b1;
    ciclos(60);
    botao_esq = 1'b0;
    ciclos(40);
    chk_int("hold_n_sub", q_sub.size() - n1, 6);
    for (int i = 0; i < 6; i++) begin
      if (n1 + i < q_sub.size()) chk_int("hold_t_sub", q_sub[n1 + i] - base, esp_hold[i]);
    end
    chk_int("hold_n_soma", q_soma.size() - n0, 0);

    // Glitch shorter than the debounce window.
    n0 = q_soma.size();
    botao_dir = 1'b1;
    ciclos(3);
    botao_dir = 1'b0;
    ciclos(20);
    chk_int("glitch_n_soma", q_soma.size() - n0, 0);

    // Both pressed: one sub, then locked until both released.
    base = t_model; n0 = q_soma.size(); n1 = q_sub.size();
    botao_esq = 1'b1;
    ciclos(14);
    botao_dir = 1'b1;
    ciclos(26);
    botao_esq = 1'b0;
    botao_dir = 1'b0;
    ciclos(20);
    chk_int("ambos_n_sub", q_sub.size() - n1, 1);
    if (q_sub.size() > n1) chk_int("ambos_t_sub", q_sub[n1] - base, 7);
    chk_int("ambos_n_soma", q_soma.size() - n0, 0);
    base = t_model; n0 = q_soma.size();
    botao_dir = 1'b1;
    ciclos(10);
    botao_dir = 1'b0;
    ciclos(30);
    chk_int("repress_n_soma", q_soma.size() - n0, 1);
    if (q_soma.size() > n0) chk_int("repress_t_soma", q_soma[n0] - base, N_DEB + 3);

    // Enable low with right held, then enable rises.
    n0 = q_soma.size();
    habilita = 1'b0;
    botao_dir = 1'b1;
    ciclos(30);
    chk_int("hab0_n_soma", q_soma.size() - n0, 0);
    base = t_model;
    habilita = 1'b1;
    ciclos(5);
    chk_int("hab1_n_soma", q_soma.size() - n0, 1);
    if (q_soma.size() > n0) chk_int("hab1_t_soma", q_soma[n0] - base, 1);
    botao_dir = 1'b0;
    ciclos(30);

    // Reset mid-hold.
    botao_dir = 1'b1;
    ciclos(15);
    zera_s = 1'b1;
    ciclos(2);
    zera_s = 1'b0;
    base = t_model; n0 = q_soma.size();
    ciclos(12);
    chk_int("rst_n_soma", q_soma.size() - n0, 1);
    if (q_soma.size() > n0) chk_int("rst_t_soma", q_soma[n0] - base, N_DEB + 3);
    botao_dir = 1'b0;
    ciclos(30);

    // Randomised segments, checked cycle by cycle against the model.
    for (int s = 0; s < 90; s++) begin
      botao_esq = 1'($urandom_range(0, 1));
      botao_dir = 1'($urandom_range(0, 1));
      habilita  = ($urandom_range(0, 9) != 0);
      zera_s    = ($urandom_range(0, 29) == 0);
      ciclos($urandom_range(1, 50));
    end
    zera_s = 1'b0;
    habilita = 1'b1;
    botao_esq = 1'b0;
    botao_dir = 1'b0;
    ciclos(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
